// File: rtl/sr_ff_array_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff_array_if
// Description : Bundles the per-bit set/clear requests and the registered
//               q/qbar outputs of an SR flip-flop bank.
//               master : drives set/reset (and conflict_clr), observes q/qbar
//                        (and conflict).
//               slave  : the flip-flop bank itself.
//               Optional macro SR_FF_CONFLICT_FLAG_EN adds the sticky
//               conflict flag and its synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_ff_array_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] reset;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
`ifdef SR_FF_CONFLICT_FLAG_EN
  logic [WIDTH-1:0] conflict;
  logic             conflict_clr;

  modport master (output set, reset, conflict_clr, input q, qbar, conflict);
  modport slave  (input set, reset, conflict_clr, output q, qbar, conflict);
`else
  modport master (output set, reset, input q, qbar);
  modport slave  (input set, reset, output q, qbar);
`endif
endinterface
`default_nettype wire

// File: rtl/sr_ff_array.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff_array
// Description : Bank of WIDTH independent clocked SR flip-flops with
//               complementary outputs. Set has priority over clear.
//               Ports:
//                 clk   - rising-edge clock
//                 rst_n - asynchronous active-low reset (q <= RESET_VAL)
//                 bus   - sr_ff_array_if.slave:
//                           set/reset  (in,  WIDTH) per-bit set / clear
//                           q/qbar     (out, WIDTH) registered state, ~state
//                           conflict_clr (in, 1)     [SR_FF_CONFLICT_FLAG_EN]
//                           conflict   (out, WIDTH) sticky set&reset flag
//                                                    [SR_FF_CONFLICT_FLAG_EN]
//               Optional macro: SR_FF_CONFLICT_FLAG_EN
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_array #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_ff_array_if.slave      bus
);

  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] state_q;

  // set forces 1, otherwise a clear forces 0, otherwise hold.
  // Written as a single bitwise expression so every bit is independent.
  always_comb begin
    state_d = bus.set | (state_q & ~bus.reset);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  // qbar is derived from the same register so q/qbar can never disagree.
  assign bus.q    = state_q;
  assign bus.qbar = ~state_q;

`ifdef SR_FF_CONFLICT_FLAG_EN
  logic [WIDTH-1:0] conflict_d;
  logic [WIDTH-1:0] conflict_q;

  // A new conflict is OR-ed in after the clear, so it survives a
  // same-cycle conflict_clr.
  always_comb begin
    conflict_d = (conflict_q & ~{WIDTH{bus.conflict_clr}}) | (bus.set & bus.reset);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= {WIDTH{1'b0}};
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign bus.conflict = conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_ff_array
// Description : Directed self-checking bench for sr_ff_array. Uses a 1-bit
//               instance (RESET_VAL=0) and a 4-bit instance
//               (RESET_VAL=4'b1010) sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ff_array;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sr_ff_array_if #(.WIDTH(1)) bus1 ();
  sr_ff_array_if #(.WIDTH(4)) bus4 ();

  sr_ff_array #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  sr_ff_array #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic s, input logic r);
    @(negedge clk);
    bus1.set   = s;
    bus1.reset = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.set = 1'b1;
    bus1.reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus1.q !== 1'b0 || bus1.qbar !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d q=%b qbar=%b expected q=0 qbar=1", i, bus1.q, bus1.qbar);
      end
    end
    checks++;
    if (bus4.q !== 4'b1010 || bus4.qbar !== 4'b0101) begin
      failures++;
      $display("FAIL reset_val4 q=%b qbar=%b expected q=1010 qbar=0101", bus4.q, bus4.qbar);
    end
`ifdef SR_FF_CONFLICT_FLAG_EN
    checks++;
    if (bus4.conflict !== 4'b0000 || bus1.conflict !== 1'b0) begin
      failures++;
      $display("FAIL reset_conflict c4=%b c1=%b expected 0000/0", bus4.conflict, bus1.conflict);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus1.q !== 1'b1 || bus1.qbar !== 1'b0) begin
      failures++;
      $display("FAIL reset_release q=%b qbar=%b expected q=1 qbar=0", bus1.q, bus1.qbar);
    end
    checks++;
    if (bus4.q !== 4'b1010) begin
      failures++;
      $display("FAIL reset_release4 q=%b expected 1010", bus4.q);
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] vec [4];
    logic       exp_q [4];
    vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11;
    exp_q[0] = 1'b0; exp_q[1] = 1'b0; exp_q[2] = 1'b1; exp_q[3] = 1'b1;
    drive1(1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive1(vec[i][1], vec[i][0]);
      step();
      checks++;
      if (bus1.q !== exp_q[i] || bus1.qbar !== ~exp_q[i]) begin
        failures++;
        $display("FAIL truth_table sr=%b q=%b qbar=%b expected q=%b qbar=%b",
                 vec[i], bus1.q, bus1.qbar, exp_q[i], ~exp_q[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive1(1'b1, 1'b0);
    step();
    drive1(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus1.q !== 1'b1 || bus1.qbar !== 1'b0) begin
        failures++;
        $display("FAIL hold_one cyc=%0d q=%b qbar=%b expected q=1 qbar=0", i, bus1.q, bus1.qbar);
      end
    end
    drive1(1'b0, 1'b1);
    step();
    checks++;
    if (bus1.q !== 1'b0 || bus1.qbar !== 1'b1) begin
      failures++;
      $display("FAIL hold_clear q=%b qbar=%b expected q=0 qbar=1", bus1.q, bus1.qbar);
    end
    drive1(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus1.q !== 1'b0 || bus1.qbar !== 1'b1) begin
        failures++;
        $display("FAIL hold_zero cyc=%0d q=%b qbar=%b expected q=0 qbar=1", i, bus1.q, bus1.qbar);
      end
    end
  endtask

  task automatic test_async_reset();
    drive1(1'b1, 1'b0);
    step();
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.q !== 1'b0 || bus1.qbar !== 1'b1) begin
      failures++;
      $display("FAIL async_reset q=%b qbar=%b expected q=0 qbar=1", bus1.q, bus1.qbar);
    end
    // set still high across an edge while in reset: must be ignored
    step();
    checks++;
    if (bus1.q !== 1'b0 || bus4.q !== 4'b1010) begin
      failures++;
      $display("FAIL async_reset_held q=%b q4=%b expected q=0 q4=1010", bus1.q, bus4.q);
    end
    @(negedge clk);
    bus1.set = 1'b0;
    bus1.reset = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus1.q !== 1'b0 || bus1.qbar !== 1'b1) begin
      failures++;
      $display("FAIL async_release q=%b qbar=%b expected q=0 qbar=1", bus1.q, bus1.qbar);
    end
  endtask

  task automatic test_multi_bit();
    checks++;
    if (bus4.q !== 4'b1010) begin
      failures++;
      $display("FAIL multi_start q=%b expected 1010", bus4.q);
    end
    @(negedge clk);
    bus4.set = 4'b0001;
    bus4.reset = 4'b1000;
    step();
    checks++;
    if (bus4.q !== 4'b0011 || bus4.qbar !== 4'b1100) begin
      failures++;
      $display("FAIL multi_mix q=%b qbar=%b expected q=0011 qbar=1100", bus4.q, bus4.qbar);
    end
    @(negedge clk);
    bus4.set = 4'b0100;
    bus4.reset = 4'b0110;
    step();
    checks++;
    if (bus4.q !== 4'b0101 || bus4.qbar !== 4'b1010) begin
      failures++;
      $display("FAIL multi_prio q=%b qbar=%b expected q=0101 qbar=1010", bus4.q, bus4.qbar);
    end
    @(negedge clk);
    bus4.set = 4'b0000;
    bus4.reset = 4'b0000;
    step();
    checks++;
    if (bus4.q !== 4'b0101) begin
      failures++;
      $display("FAIL multi_hold q=%b expected 0101", bus4.q);
    end
  endtask

`ifdef SR_FF_CONFLICT_FLAG_EN
  task automatic test_conflict();
    @(negedge clk);
    bus4.set = 4'b0001;
    bus4.reset = 4'b0001;
    bus4.conflict_clr = 1'b0;
    step();
    checks++;
    if (bus4.conflict !== 4'b0001 || bus4.q[0] !== 1'b1) begin
      failures++;
      $display("FAIL conflict_set conflict=%b q=%b expected conflict=0001 q[0]=1", bus4.conflict, bus4.q);
    end
    @(negedge clk);
    bus4.set = 4'b0000;
    bus4.reset = 4'b0000;
    step();
    checks++;
    if (bus4.conflict !== 4'b0001) begin
      failures++;
      $display("FAIL conflict_sticky conflict=%b expected 0001", bus4.conflict);
    end
    @(negedge clk);
    bus4.conflict_clr = 1'b1;
    step();
    checks++;
    if (bus4.conflict !== 4'b0000) begin
      failures++;
      $display("FAIL conflict_clear conflict=%b expected 0000", bus4.conflict);
    end
    @(negedge clk);
    bus4.set = 4'b0001;
    bus4.reset = 4'b0001;
    step();
    checks++;
    if (bus4.conflict !== 4'b0001) begin
      failures++;
      $display("FAIL conflict_clr_prio conflict=%b expected 0001", bus4.conflict);
    end
    @(negedge clk);
    bus4.set = 4'b0000;
    bus4.reset = 4'b0000;
    bus4.conflict_clr = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus1.set = 1'b0;
    bus1.reset = 1'b0;
    bus4.set = 4'b0000;
    bus4.reset = 4'b0000;
`ifdef SR_FF_CONFLICT_FLAG_EN
    bus1.conflict_clr = 1'b0;
    bus4.conflict_clr = 1'b0;
`endif
    test_reset();
    test_truth_table();
    test_hold();
    test_async_reset();
    test_multi_bit();
`ifdef SR_FF_CONFLICT_FLAG_EN
    test_conflict();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
